// File: rtl/target_field_engine_pkg.sv
// target_field_engine_pkg: shared state encoding and collision window helper
package target_field_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } stateT;

    // Symmetric window test written so neither side can underflow.
    function automatic logic withinWin(input int a, input int b, input int half);
        return (a <= b + half) && (b <= a + half);
    endfunction

endpackage

// File: rtl/target_field_engine_lane.sv
// target_lane: one target bouncing in its lane, with direction and hit flag
module target_lane
    import target_field_engine_pkg::*;
#(
    parameter int LANE     = 0,
    parameter int X_W      = 10,
    parameter int X_INIT   = 200,
    parameter int X_MIN    = 10,
    parameter int X_MAX    = 612,
    parameter int SPEED    = 2,
    parameter bit DIR_INIT = (LANE % 2) == 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           run,
    input  logic           clear,
    input  logic           hitStrobe,
    output logic [X_W-1:0] x,
    output logic           hit
);

    localparam logic [X_W-1:0] INIT_X    = X_W'(X_INIT);
    localparam logic [X_W-1:0] LO        = X_W'(X_MIN);
    localparam logic [X_W-1:0] HI        = X_W'(X_MAX);
    localparam logic [X_W-1:0] RIGHT_TURN = X_W'(X_MAX - SPEED);
    localparam logic [X_W-1:0] LEFT_TURN  = X_W'(X_MIN + SPEED);
    localparam logic [X_W-1:0] STEP      = X_W'(SPEED);

    logic dir;

    // A strobed target latches its hit and skips this tick's motion.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            x   <= INIT_X;
            dir <= DIR_INIT;
            hit <= 1'b0;
        end else if (tick) begin
            if (clear) begin
                x   <= INIT_X;
                dir <= DIR_INIT;
                hit <= 1'b0;
            end else if (hitStrobe)
                hit <= 1'b1;
            else if (run && !hit) begin
                if (!dir) begin
                    x   <= (x >= RIGHT_TURN) ? HI : x + STEP;
                    dir <= x >= RIGHT_TURN;
                end else begin
                    x   <= (x <= LEFT_TURN) ? LO : x - STEP;
                    dir <= !(x <= LEFT_TURN);
                end
            end
        end

endmodule

// File: rtl/target_field_engine.sv
// target_field_engine: ship, bullet, target lanes, scoring and round FSM
module target_field_engine
    import target_field_engine_pkg::*;
#(
    parameter int N_TARGETS   = 2,
    parameter int X_W         = 10,
    parameter int X_MIN       = 10,
    parameter int X_MAX       = 612,
    parameter int LANE_Y0     = 250,
    parameter int LANE_PITCH  = 75,
    parameter int TGT_X0      = 200,
    parameter int TGT_XSTEP   = 150,
    parameter int TGT_SPEED   = 2,
    parameter int HALF_W      = 10,
    parameter int SHIP_X0     = 400,
    parameter int SHIP_MIN    = 30,
    parameter int SHIP_MAX    = 610,
    parameter int SHIP_STEP   = 5,
    parameter int BULLET_Y0   = 430,
    parameter int BULLET_STEP = 10,
    parameter int SCORE_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     start,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_fire,
    output logic [1:0]               state,
    output logic [X_W-1:0]           ship_x,
    output logic                     bullet_active,
    output logic [X_W-1:0]           bullet_x,
    output logic [X_W-1:0]           bullet_y,
    output logic [N_TARGETS*X_W-1:0] target_x,
    output logic [N_TARGETS-1:0]     target_hit,
    output logic                     all_hit,
    output logic [SCORE_W-1:0]       score,
    output logic [3:0]               round_cnt
);

    localparam logic [X_W-1:0] SHIP_INIT = X_W'(SHIP_X0);
    localparam logic [X_W-1:0] SHIP_LO   = X_W'(SHIP_MIN);
    localparam logic [X_W-1:0] SHIP_HI   = X_W'(SHIP_MAX);
    localparam logic [X_W-1:0] SHIP_LO_TURN = X_W'(SHIP_MIN + SHIP_STEP);
    localparam logic [X_W-1:0] SHIP_HI_TURN = X_W'(SHIP_MAX - SHIP_STEP);
    localparam logic [X_W-1:0] SSTEP     = X_W'(SHIP_STEP);
    localparam logic [X_W-1:0] B_Y0      = X_W'(BULLET_Y0);
    localparam logic [X_W-1:0] B_STEP    = X_W'(BULLET_STEP);

    stateT stateQ;
    logic [N_TARGETS-1:0] cand, hitStrobe, postHit;
    logic [X_W-1:0] shipNext;
    logic fireReq, play;

    assign state   = stateQ;
    assign play    = stateQ == ST_PLAY;
    assign all_hit = &target_hit;
    assign fireReq = btn_fire && !btn_left && !btn_right;

    genvar g;
    generate
        for (g = 0; g < N_TARGETS; g++) begin : gLane
            assign cand[g] = play && bullet_active && !target_hit[g]
                && withinWin(int'(bullet_x), int'(target_x[g*X_W +: X_W]), HALF_W)
                && withinWin(int'(bullet_y), int'(X_W'(LANE_Y0 - g*LANE_PITCH)), HALF_W);
            target_lane #(
                .LANE(g), .X_W(X_W), .X_INIT(TGT_X0 + g*TGT_XSTEP), .X_MIN(X_MIN),
                .X_MAX(X_MAX), .SPEED(TGT_SPEED), .DIR_INIT((g % 2) == 1)
            ) uLane (
                .clk(clk), .reset(reset), .tick(tick), .run(play),
                .clear(stateQ == ST_DONE && !start), .hitStrobe(hitStrobe[g]),
                .x(target_x[g*X_W +: X_W]), .hit(target_hit[g])
            );
        end
    endgenerate

    // Only the lowest-index overlapping target takes the bullet.
    assign hitStrobe = cand & (~cand + N_TARGETS'(1));
    assign postHit   = target_hit | hitStrobe;

    assign shipNext = (btn_right && !btn_left) ? ((ship_x >= SHIP_HI_TURN) ? SHIP_HI : ship_x + SSTEP)
                    : (btn_left && !btn_right) ? ((ship_x <= SHIP_LO_TURN) ? SHIP_LO : ship_x - SSTEP)
                    : ship_x;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stateQ        <= ST_IDLE;
            ship_x        <= SHIP_INIT;
            bullet_active <= 1'b0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            score         <= '0;
            round_cnt     <= '0;
        end else if (tick) begin
            case (stateQ)
                ST_IDLE: if (start) stateQ <= ST_PLAY;
                ST_PLAY: begin
                    ship_x <= shipNext;
                    if (!bullet_active) begin
                        if (fireReq) begin
                            bullet_active <= 1'b1;
                            bullet_x      <= ship_x;
                            bullet_y      <= B_Y0;
                        end
                    end else if (|hitStrobe) begin
                        bullet_active <= 1'b0;
                        score         <= (&score) ? score : score + SCORE_W'(1);
                    end else if (bullet_y < B_STEP)
                        bullet_active <= 1'b0;
                    else
                        bullet_y <= bullet_y - B_STEP;
                    if (&postHit) begin
                        stateQ        <= ST_DONE;
                        bullet_active <= 1'b0;
                        round_cnt     <= round_cnt + 4'd1;
                    end
                end
                ST_DONE: if (!start) begin
                    stateQ        <= ST_IDLE;
                    ship_x        <= SHIP_INIT;
                    bullet_active <= 1'b0;
                    bullet_x      <= '0;
                    bullet_y      <= '0;
                end
                default: stateQ <= ST_IDLE;
            endcase
        end

endmodule
